// File: rtl/demux_pkg.sv
// Shared definitions for the 1x4 stream demux and its 4x1 mux siblings:
// decode modes, slot state encoding and the select-mask decoder.
package demux_pkg;

  localparam int MODE_PARALLEL = 0;
  localparam int MODE_PRIORITY = 1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Returns {valid, index[1:0]}. Parallel mode only accepts a one-hot mask;
  // priority mode takes the lowest set bit.
  function automatic logic [2:0] decode_sel(input logic [3:0] sel, input int mode);
    logic [2:0] res;
    res = 3'b000;
    if (mode == MODE_PARALLEL) begin
      case (sel)
        4'b0001: res = 3'b100;
        4'b0010: res = 3'b101;
        4'b0100: res = 3'b110;
        4'b1000: res = 3'b111;
        default: res = 3'b000;
      endcase
    end else begin
      if (sel[0])      res = 3'b100;
      else if (sel[1]) res = 3'b101;
      else if (sel[2]) res = 3'b110;
      else if (sel[3]) res = 3'b111;
      else             res = 3'b000;
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register with a valid/ready handshake toward downstream.
//   state      | meaning
//   SLOT_EMPTY | no beat held, valid_out low
//   SLOT_FULL  | beat held in r_data, valid_out high until popped
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] y_out
);

  slot_state_e      r_state;
  slot_state_e      w_next;
  logic [WIDTH-1:0] r_data;
  logic             w_pop;

  assign valid_out = (r_state == SLOT_FULL);
  assign y_out     = r_data;
  assign w_pop     = valid_out && ready_in;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (push_in) r_data <= d_in;
    end
  end

  // The top only pushes a full slot when it is being popped in the same cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (push_in) w_next = SLOT_FULL;
      SLOT_FULL:  if (w_pop && !push_in) w_next = SLOT_EMPTY;
      default:    w_next = SLOT_EMPTY;
    endcase
  end

endmodule

// File: rtl/demux_1x4_stream.sv
// Registered 1-to-4 stream demux: decodes the select mask, steers accepted
// beats into per-channel slots, and drops/counts invalid-select beats.
module demux_1x4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int MODE  = MODE_PRIORITY
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [WIDTH-1:0]   d_in,
  input  logic [3:0]         sel_in,
  input  logic               valid_in,
  output logic               ready_out,
  output logic [4*WIDTH-1:0] y_out,
  output logic [3:0]         valid_out,
  input  logic [3:0]         ready_in,
  output logic               err_out,
  output logic [7:0]         drop_cnt_out
);

  logic [2:0] w_dec;
  logic       w_sel_ok;
  logic [1:0] w_tgt;
  logic [3:0] w_full;
  logic [3:0] w_push;
  logic       w_accept;
  logic       w_drop;
  logic       r_err;
  logic [7:0] r_drop_cnt;

  assign w_dec    = decode_sel(sel_in, MODE);
  assign w_sel_ok = w_dec[2];
  assign w_tgt    = w_dec[1:0];

  // Invalid selects are always accepted so the source never stalls on them.
  always_comb begin
    ready_out = 1'b0;
    if (!rst_in) begin
      if (!w_sel_ok) ready_out = 1'b1;
      else           ready_out = !w_full[w_tgt] || ready_in[w_tgt];
    end
  end

  assign w_accept = valid_in && ready_out;
  assign w_drop   = w_accept && !w_sel_ok;

  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign w_push[i] = w_accept && w_sel_ok && (w_tgt == 2'(i));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_in   (w_push[i]),
      .d_in      (d_in),
      .ready_in  (ready_in[i]),
      .valid_out (w_full[i]),
      .y_out     (y_out[i*WIDTH +: WIDTH])
    );
  end

  assign valid_out = w_full;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_err      <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_err <= w_drop;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign err_out      = r_err;
  assign drop_cnt_out = r_drop_cnt;

endmodule

// File: tb/tb_demux_1x4_stream.sv
// Self-checking bench: a parallel-decode and a priority-decode instance share
// stimulus; each is compared every cycle against a queue-style channel model.
module tb_demux_1x4_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  d;
  logic [3:0]  sel;
  logic        vin;
  logic [3:0]  rdy;

  logic        ro  [2];
  logic [31:0] y   [2];
  logic [3:0]  vo  [2];
  logic        err [2];
  logic [7:0]  cnt [2];

  bit          mf [2][4];
  logic [7:0]  md [2][4];
  logic        me [2];
  int          mc [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1x4_stream #(.WIDTH(8), .MODE(0)) dut_par (
    .clk_in(clk), .rst_in(rst), .d_in(d), .sel_in(sel), .valid_in(vin),
    .ready_out(ro[0]), .y_out(y[0]), .valid_out(vo[0]), .ready_in(rdy),
    .err_out(err[0]), .drop_cnt_out(cnt[0])
  );

  demux_1x4_stream #(.WIDTH(8), .MODE(1)) dut_pri (
    .clk_in(clk), .rst_in(rst), .d_in(d), .sel_in(sel), .valid_in(vin),
    .ready_out(ro[1]), .y_out(y[1]), .valid_out(vo[1]), .ready_in(rdy),
    .err_out(err[1]), .drop_cnt_out(cnt[1])
  );

  // mode 0: exactly one bit set; mode 1: lowest set bit
  function automatic void dec(input int mode, input logic [3:0] s, output bit ok, output int t);
    ok = 0;
    t  = 0;
    if (mode == 0) begin
      if ($countones(s) == 1)
        for (int i = 0; i < 4; i++) if (s[i]) t = i;
      ok = ($countones(s) == 1);
    end else begin
      for (int i = 3; i >= 0; i--)
        if (s[i]) begin ok = 1; t = i; end
    end
  endfunction

  function automatic bit exp_ready(input int k);
    bit ok;
    int t;
    if (rst) return 1'b0;
    dec(k, sel, ok, t);
    if (!ok) return 1'b1;
    return !mf[k][t] || rdy[t];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [3:0] s,
                     input logic [7:0] dd, input logic [3:0] rr);
    bit          acc [2];
    bit          ok;
    int          t;
    logic [3:0]  ev;
    logic [31:0] ey;
    @(negedge clk);
    rst = r; vin = v; sel = s; d = dd; rdy = rr;
    #1;
    for (int k = 0; k < 2; k++) begin
      acc[k] = v && exp_ready(k);
      chk($sformatf("ready_out[m%0d]", k), {31'd0, ro[k]}, {31'd0, exp_ready(k)});
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        for (int i = 0; i < 4; i++) begin mf[k][i] = 0; md[k][i] = 8'h00; end
        me[k] = 1'b0;
        mc[k] = 0;
      end else begin
        dec(k, s, ok, t);
        for (int i = 0; i < 4; i++) if (mf[k][i] && rr[i]) mf[k][i] = 0;
        if (acc[k] && ok) begin mf[k][t] = 1; md[k][t] = dd; end
        me[k] = acc[k] && !ok;
        if (acc[k] && !ok && mc[k] < 255) mc[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin
        ev[i]         = mf[k][i];
        ey[i*8 +: 8]  = md[k][i];
      end
      chk($sformatf("valid_out[m%0d]", k), {28'd0, vo[k]}, {28'd0, ev});
      chk($sformatf("y_out[m%0d]", k), y[k], ey);
      chk($sformatf("err_out[m%0d]", k), {31'd0, err[k]}, {31'd0, me[k]});
      chk($sformatf("drop_cnt[m%0d]", k), {24'd0, cnt[k]}, mc[k]);
    end
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; sel = 4'h0; d = 8'h00; rdy = 4'hF;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) begin mf[k][i] = 0; md[k][i] = 8'h00; end
      me[k] = 0; mc[k] = 0;
    end

    cyc(1, 0, 4'h0, 8'h00, 4'hF);
    cyc(1, 1, 4'h1, 8'h5A, 4'hF);
    chk("reset valid_out", {28'd0, vo[1]}, 32'h0);

    // mixed mask: priority routes to ch1, parallel drops it
    cyc(0, 1, 4'b0110, 8'hA5, 4'hF);
    chk("pri ch1 data", {24'd0, y[1][15:8]}, 32'hA5);
    chk("par drop count", {24'd0, cnt[0]}, 32'd1);
    cyc(0, 0, 4'h0, 8'h00, 4'hF);
    chk("par err one cycle", {31'd0, err[0]}, 32'd0);
    cyc(0, 1, 4'b0000, 8'h3C, 4'hF);
    cyc(0, 0, 4'h0, 8'h00, 4'hF);

    // backpressure on ch2
    cyc(0, 1, 4'b0100, 8'h11, 4'b1011);
    cyc(0, 1, 4'b0100, 8'h22, 4'b1011);
    chk("stalled ready_out", {31'd0, ro[1]}, 32'd0);
    cyc(0, 1, 4'b0001, 8'h33, 4'b1011);
    chk("ch2 held", {24'd0, y[1][23:16]}, 32'h11);
    cyc(0, 1, 4'b0100, 8'h22, 4'hF);
    chk("ch2 follows", {24'd0, y[1][23:16]}, 32'h22);
    cyc(0, 0, 4'h0, 8'h00, 4'hF);

    // streaming 0..15 into ch3
    for (int i = 0; i < 16; i++) begin
      cyc(0, 1, 4'b1000, 8'(i), 4'hF);
      chk("stream ch3", {24'd0, y[1][31:24]}, i);
    end
    cyc(0, 0, 4'h0, 8'h00, 4'hF);

    // drop counter saturation
    for (int i = 0; i < 300; i++) cyc(0, 1, 4'b0000, 8'(i), 4'hF);
    chk("sat count", {24'd0, cnt[1]}, 32'd255);
    cyc(0, 0, 4'h0, 8'h00, 4'hF);

    // reset with ch1 full and stalled
    cyc(0, 1, 4'b0010, 8'h77, 4'b1101);
    cyc(0, 0, 4'h0, 8'h00, 4'b1101);
    cyc(1, 1, 4'b0010, 8'h88, 4'b1101);
    chk("post-reset valid", {28'd0, vo[1]}, 32'h0);
    chk("post-reset count", {24'd0, cnt[1]}, 32'd0);
    cyc(0, 1, 4'b0010, 8'h99, 4'hF);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom), 4'($urandom),
          8'($urandom), 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
